// File: rtl/vram_port_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | vram_port_pkg                                                    |
// | Register selects, FSM states and address-step constants.         |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package vram_port_pkg;

    localparam logic [2:0] SEL_VMAIN   = 3'd0;
    localparam logic [2:0] SEL_VMADDL  = 3'd1;
    localparam logic [2:0] SEL_VMADDH  = 3'd2;
    localparam logic [2:0] SEL_VMDATAL = 3'd3;
    localparam logic [2:0] SEL_VMDATAH = 3'd4;
    localparam logic [2:0] SEL_RDVRAML = 3'd5;
    localparam logic [2:0] SEL_RDVRAMH = 3'd6;
    localparam logic [2:0] SEL_NONE    = 3'd7;

    localparam logic [14:0] C_STEP_1   = 15'd1;
    localparam logic [14:0] C_STEP_32  = 15'd32;
    localparam logic [14:0] C_STEP_128 = 15'd128;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR_WAIT = 2'd1,
        ST_PF_WAIT = 2'd2
    } state_t;

    function automatic logic [14:0] step_size(input logic [1:0] step);
        case (step)
            2'd0:    step_size = C_STEP_1;
            2'd1:    step_size = C_STEP_32;
            default: step_size = C_STEP_128;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/vram_port_ctl_if.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | vram_port_ctl_if                                                 |
// | PPU register-side strobes plus the two byte-wide VRAM ports.     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface vram_port_ctl_if;
    logic        reg_wr;
    logic        reg_rd;
    logic [2:0]  reg_sel;
    logic [7:0]  reg_din;
    logic [7:0]  reg_dout;
    logic        blocked;
    logic        busy;
    logic [14:0] vram1_addr;
    logic [14:0] vram2_addr;
    logic        vram1_req;
    logic        vram2_req;
    logic        vram1_ack;
    logic        vram2_ack;
    logic        vram1_we;
    logic        vram2_we;
    logic [7:0]  vram1_din;
    logic [7:0]  vram2_din;
    logic [7:0]  vram1_dout;
    logic [7:0]  vram2_dout;

    modport master (
        input  reg_wr, reg_rd, reg_sel, reg_din, blocked,
        input  vram1_ack, vram2_ack, vram1_dout, vram2_dout,
        output reg_dout, busy,
        output vram1_addr, vram2_addr, vram1_req, vram2_req,
        output vram1_we, vram2_we, vram1_din, vram2_din
    );

    modport slave (
        output reg_wr, reg_rd, reg_sel, reg_din, blocked,
        output vram1_ack, vram2_ack, vram1_dout, vram2_dout,
        input  reg_dout, busy,
        input  vram1_addr, vram2_addr, vram1_req, vram2_req,
        input  vram1_we, vram2_we, vram1_din, vram2_din
    );
endinterface
`default_nettype wire

// File: rtl/vram_addr_remap.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | vram_addr_remap                                                  |
// | Rotates the low 8/9/10 address bits left by 3 (built only when   |
// | VRAM_PORT_REMAP_EN is defined).                                  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`ifdef VRAM_PORT_REMAP_EN
module vram_addr_remap (
    input  logic [14:0] i_addr,
    input  logic [1:0]  i_mode,
    output logic [14:0] o_addr
);
    always_comb begin
        case (i_mode)
            2'd1:    o_addr = {i_addr[14:8],  i_addr[4:0], i_addr[7:5]};
            2'd2:    o_addr = {i_addr[14:9],  i_addr[5:0], i_addr[8:6]};
            2'd3:    o_addr = {i_addr[14:10], i_addr[6:0], i_addr[9:7]};
            default: o_addr = i_addr;
        endcase
    end
endmodule
`endif
`default_nettype wire

// File: rtl/vram_port_ctl.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | vram_port_ctl                                                    |
// | CPU-side VRAM access port: register decode, increment, remap     |
// | (VRAM_PORT_REMAP_EN) and toggle req/ack VRAM handshake.          |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module vram_port_ctl
    import vram_port_pkg::*;
(
    input  logic            clk,
    input  logic            resetn,
    vram_port_ctl_if.master bus
);

    state_t      r_state, w_state_nxt;
    logic        r_inc_hi;
    logic [1:0]  r_remap;
    logic [1:0]  r_step;
    logic [14:0] r_addr;
    logic [15:0] r_latch;
    logic [7:0]  r_dout;
    logic        r_inc_pend;
    logic [14:0] r_v1_addr, r_v2_addr;
    logic        r_req1, r_req2, r_we1, r_we2;
    logic [7:0]  r_din1, r_din2;

    logic        w_busy, w_ok, w_wr, w_rd, w_finish, w_done;
    logic        w_start_wr1, w_start_wr2, w_start_pf, w_blk_inc;
    logic [14:0] w_src_addr, w_vaddr, w_addr_inc;

    assign w_busy = (r_state != ST_IDLE);
    assign w_ok   = ~w_busy & (bus.reg_wr ^ bus.reg_rd) & (bus.reg_sel != SEL_NONE);
    assign w_wr   = w_ok & bus.reg_wr;
    assign w_rd   = w_ok & bus.reg_rd;

    assign w_start_wr1 = w_wr & (bus.reg_sel == SEL_VMDATAL) & ~bus.blocked;
    assign w_start_wr2 = w_wr & (bus.reg_sel == SEL_VMDATAH) & ~bus.blocked;
    assign w_start_pf  = (w_wr & ((bus.reg_sel == SEL_VMADDL) | (bus.reg_sel == SEL_VMADDH)))
                       | (w_rd & (bus.reg_sel == SEL_RDVRAML) & ~r_inc_hi)
                       | (w_rd & (bus.reg_sel == SEL_RDVRAMH) &  r_inc_hi);
    // Suppressed data writes still advance the address, immediately.
    assign w_blk_inc   = w_wr & bus.blocked
                       & (((bus.reg_sel == SEL_VMDATAL) & ~r_inc_hi)
                        | ((bus.reg_sel == SEL_VMDATAH) &  r_inc_hi));

    assign w_done     = (bus.vram1_ack == r_req1) & (bus.vram2_ack == r_req2);
    assign w_addr_inc = r_addr + step_size(r_step);

    // Address-register writes prefetch from the address being written.
    always_comb begin
        w_src_addr = r_addr;
        if (w_wr && bus.reg_sel == SEL_VMADDL)
            w_src_addr = {r_addr[14:8], bus.reg_din};
        else if (w_wr && bus.reg_sel == SEL_VMADDH)
            w_src_addr = {bus.reg_din[6:0], r_addr[7:0]};
    end

`ifdef VRAM_PORT_REMAP_EN
    vram_addr_remap u_remap (
        .i_addr (w_src_addr),
        .i_mode (r_remap),
        .o_addr (w_vaddr)
    );
`else
    logic w_unused_remap;
    assign w_unused_remap = ^r_remap;
    assign w_vaddr        = w_src_addr;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_finish    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start_wr1 || w_start_wr2)
                    w_state_nxt = ST_WR_WAIT;
                else if (w_start_pf)
                    w_state_nxt = ST_PF_WAIT;
            end
            ST_WR_WAIT, ST_PF_WAIT: begin
                if (w_done) begin
                    w_state_nxt = ST_IDLE;
                    w_finish    = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_inc_hi   <= 1'b0;
            r_remap    <= 2'd0;
            r_step     <= 2'd0;
            r_addr     <= 15'd0;
            r_latch    <= 16'd0;
            r_dout     <= 8'd0;
            r_inc_pend <= 1'b0;
            r_v1_addr  <= 15'd0;
            r_v2_addr  <= 15'd0;
            r_req1     <= 1'b0;
            r_req2     <= 1'b0;
            r_we1      <= 1'b0;
            r_we2      <= 1'b0;
            r_din1     <= 8'd0;
            r_din2     <= 8'd0;
        end else begin
            if (w_wr && bus.reg_sel == SEL_VMAIN) begin
                r_inc_hi <= bus.reg_din[7];
                r_remap  <= bus.reg_din[3:2];
                r_step   <= bus.reg_din[1:0];
            end
            if (w_wr && bus.reg_sel == SEL_VMADDL)
                r_addr[7:0] <= bus.reg_din;
            if (w_wr && bus.reg_sel == SEL_VMADDH)
                r_addr[14:8] <= bus.reg_din[6:0];
            if (w_blk_inc || (w_finish && r_inc_pend))
                r_addr <= w_addr_inc;

            if (w_rd && bus.reg_sel == SEL_RDVRAML)
                r_dout <= r_latch[7:0];
            if (w_rd && bus.reg_sel == SEL_RDVRAMH)
                r_dout <= r_latch[15:8];

            if (w_start_wr1) begin
                r_req1     <= ~r_req1;
                r_we1      <= 1'b1;
                r_din1     <= bus.reg_din;
                r_v1_addr  <= w_vaddr;
                r_inc_pend <= ~r_inc_hi;
            end
            if (w_start_wr2) begin
                r_req2     <= ~r_req2;
                r_we2      <= 1'b1;
                r_din2     <= bus.reg_din;
                r_v2_addr  <= w_vaddr;
                r_inc_pend <= r_inc_hi;
            end
            if (w_start_pf) begin
                r_req1     <= ~r_req1;
                r_req2     <= ~r_req2;
                r_we1      <= 1'b0;
                r_we2      <= 1'b0;
                r_v1_addr  <= w_vaddr;
                r_v2_addr  <= w_vaddr;
                r_inc_pend <= w_rd;
            end
            if (w_finish && r_state == ST_PF_WAIT)
                r_latch <= {bus.vram2_dout, bus.vram1_dout};
        end
    end

    assign bus.busy       = w_busy;
    assign bus.reg_dout   = r_dout;
    assign bus.vram1_addr = r_v1_addr;
    assign bus.vram2_addr = r_v2_addr;
    assign bus.vram1_req  = r_req1;
    assign bus.vram2_req  = r_req2;
    assign bus.vram1_we   = r_we1;
    assign bus.vram2_we   = r_we2;
    assign bus.vram1_din  = r_din1;
    assign bus.vram2_din  = r_din2;

endmodule
`default_nettype wire
